toggle_activity_monitor: RTL and testbench

// - Downstream measurement stage for the synthesized power sub-circuits.
// - Samples the primary inputs and outputs of a combinational sub-circuit (e.g. n_1..n_4, n_9) once per clock.
// - Accumulates switching activity (bit toggles) and signal-high counts over a programmable window.
// - Reports one result per window over a valid/ready handshake to the power-estimation collector.

---
 rtl/toggle_activity_monitor_if.sv | 38 +++
 rtl/toggle_activity_monitor.sv | 144 ++++++++++++++
 tb/tb_toggle_activity_monitor.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_activity_monitor_if.sv
// Handshake/result bundle for toggle_activity_monitor.
// res_peak is present only when TOGGLE_MON_PEAK_EN is defined.
interface toggle_activity_monitor_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned WIN_W = 16,
   parameter int unsigned CNT_W = 20
) ();
   localparam int unsigned PCW = $clog2(WIDTH + 1);

   logic             start;
   logic [WIN_W-1:0] win_len;
   logic [WIDTH-1:0] sig_in;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_toggles;
   logic [CNT_W-1:0] res_ones;
   logic             res_ovf;
`ifdef TOGGLE_MON_PEAK_EN
   logic [PCW-1:0]   res_peak;
`endif

   modport master (
      output start, win_len, sig_in, res_ready,
      input  busy, res_valid, res_toggles, res_ones, res_ovf
`ifdef TOGGLE_MON_PEAK_EN
      , input res_peak
`endif
   );

   modport slave (
      input  start, win_len, sig_in, res_ready,
      output busy, res_valid, res_toggles, res_ones, res_ovf
`ifdef TOGGLE_MON_PEAK_EN
      , output res_peak
`endif
   );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Counts bit toggles and high-cycles of sig_in over a programmable window and reports
// one saturating result per window. Define TOGGLE_MON_PEAK_EN to add the res_peak output.
module toggle_activity_monitor #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned WIN_W = 16,
   parameter int unsigned CNT_W = 20
) (
   input logic                      clk,
   input logic                      rst_n,
   toggle_activity_monitor_if.slave mon
);
   localparam int unsigned PCW = $clog2(WIDTH + 1);
   localparam int unsigned CW1 = CNT_W + 1;

   typedef enum logic [1:0] {StIdle, StRun, StReport} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIN_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] tog_q, tog_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic             ovf_q, ovf_d;
   logic [PCW-1:0]   tog_pc, one_pc;
   logic             tog_sat, one_sat;
   logic             accept;

   function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [PCW-1:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt = cnt + PCW'(v[i]);
      end
      return cnt;
   endfunction

   // Returns {saturated, sum}; the sum clamps at all-ones.
   function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] acc,
                                              input logic [PCW-1:0]   inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, acc} + CW1'(inc);
      if (sum[CNT_W]) begin
         sum = {1'b1, {CNT_W{1'b1}}};
      end
      return sum;
   endfunction

   assign tog_pc = popcount(mon.sig_in ^ prev_q);
   assign one_pc = popcount(mon.sig_in);
   assign accept = (state_q == StIdle) && mon.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         prev_q  <= '0;
         cyc_q   <= '0;
         tog_q   <= '0;
         ones_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cyc_q   <= cyc_d;
         tog_q   <= tog_d;
         ones_q  <= ones_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (mon.start) begin
               state_d = (mon.win_len == '0) ? StReport : StRun;
            end
         end
         StRun: begin
            if (cyc_q == WIN_W'(1)) begin
               state_d = StReport;
            end
         end
         StReport: begin
            if (mon.res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      prev_d  = prev_q;
      cyc_d   = cyc_q;
      tog_d   = tog_q;
      ones_d  = ones_q;
      ovf_d   = ovf_q;
      tog_sat = 1'b0;
      one_sat = 1'b0;
      if (accept) begin
         prev_d = mon.sig_in;
         cyc_d  = mon.win_len;
         tog_d  = '0;
         ones_d = '0;
         ovf_d  = 1'b0;
      end else if (state_q == StRun) begin
         {tog_sat, tog_d}  = sat_add(tog_q, tog_pc);
         {one_sat, ones_d} = sat_add(ones_q, one_pc);
         ovf_d  = ovf_q | tog_sat | one_sat;
         prev_d = mon.sig_in;
         cyc_d  = cyc_q - WIN_W'(1);
      end
   end

`ifdef TOGGLE_MON_PEAK_EN
   logic [PCW-1:0] peak_q, peak_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   always_comb begin
      peak_d = peak_q;
      if (accept) begin
         peak_d = '0;
      end else if ((state_q == StRun) && (tog_pc > peak_q)) begin
         peak_d = tog_pc;
      end
   end

   assign mon.res_peak = peak_q;
`endif

   always_comb begin
      mon.busy        = (state_q != StIdle);
      mon.res_valid   = (state_q == StReport);
      mon.res_toggles = tog_q;
      mon.res_ones    = ones_q;
      mon.res_ovf     = ovf_q;
   end
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench for toggle_activity_monitor: a full-width instance and a CNT_W=4 instance
// for saturation; expected results are queued at stimulus time and checked on handshake.
module tb_toggle_activity_monitor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   toggle_activity_monitor_if #(.WIDTH(4), .WIN_W(16), .CNT_W(20)) m ();
   toggle_activity_monitor_if #(.WIDTH(4), .WIN_W(16), .CNT_W(4))  s ();

   toggle_activity_monitor #(.WIDTH(4), .WIN_W(16), .CNT_W(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (m)
   );

   toggle_activity_monitor #(.WIDTH(4), .WIN_W(16), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (s)
   );

   typedef struct packed {
      logic [19:0] tog;
      logic [19:0] ones;
      logic        ovf;
      logic [2:0]  peak;
   } exp_t;

   exp_t m_q[$];
   exp_t s_q[$];

   function automatic exp_t mk_exp(input int tog, input int ones, input bit ovf, input int peak);
      exp_t e;
      e.tog  = 20'(tog);
      e.ones = 20'(ones);
      e.ovf  = ovf;
      e.peak = 3'(peak);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard monitors: one result per accepted handshake.
   always @(negedge clk) begin
      if (rst_n && m.res_valid && m.res_ready) begin
         check("main result expected", 32'(m_q.size() > 0), 32'(1));
         if (m_q.size() > 0) begin
            exp_t e;
            e = m_q.pop_front();
            check("main toggles", 32'(m.res_toggles), 32'(e.tog));
            check("main ones", 32'(m.res_ones), 32'(e.ones));
            check("main ovf", 32'(m.res_ovf), 32'(e.ovf));
`ifdef TOGGLE_MON_PEAK_EN
            check("main peak", 32'(m.res_peak), 32'(e.peak));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && s.res_valid && s.res_ready) begin
         check("sat result expected", 32'(s_q.size() > 0), 32'(1));
         if (s_q.size() > 0) begin
            exp_t e;
            e = s_q.pop_front();
            check("sat toggles", 32'(s.res_toggles), 32'(e.tog));
            check("sat ones", 32'(s.res_ones), 32'(e.ones));
            check("sat ovf", 32'(s.res_ovf), 32'(e.ovf));
`ifdef TOGGLE_MON_PEAK_EN
            check("sat peak", 32'(s.res_peak), 32'(e.peak));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic do_start(input logic [15:0] len, input logic [3:0] ref_sig);
      m.start   = 1'b1;
      m.win_len = len;
      m.sig_in  = ref_sig;
      @(posedge clk); #1;
      m.start = 1'b0;
   endtask

   // vecs holds the per-cycle samples, 4 bits each, first sample in the low nibble.
   // pulse_at >= 0 pulses start (with a different win_len) during that RUN cycle.
   task automatic run_window(input logic [15:0] len, input logic [3:0] ref_sig,
                             input logic [63:0] vecs, input int pulse_at);
      do_start(len, ref_sig);
      for (int i = 0; i < int'(len); i++) begin
         m.sig_in = vecs[4*i +: 4];
         if (i == pulse_at) begin
            m.start   = 1'b1;
            m.win_len = 16'd7;
         end
         check("run busy", 32'(m.busy), 32'(1));
         check("run no valid", 32'(m.res_valid), 32'(0));
         @(posedge clk); #1;
         m.start = 1'b0;
      end
      check("valid latency", 32'(m.res_valid), 32'(1));
   endtask

   task automatic finish_handshake(input bit pulse);
      if (pulse) begin
         m.start   = 1'b1;
         m.win_len = 16'd5;
      end
      @(posedge clk); #1;
      m.start = 1'b0;
      check("post handshake valid", 32'(m.res_valid), 32'(0));
      check("post handshake busy", 32'(m.busy), 32'(0));
   endtask

   initial begin
      m.start = 1'b0; m.win_len = '0; m.sig_in = '0; m.res_ready = 1'b1;
      s.start = 1'b0; s.win_len = '0; s.sig_in = '0; s.res_ready = 1'b1;
      #2;
      check("reset busy", 32'(m.busy), 32'(0));
      check("reset valid", 32'(m.res_valid), 32'(0));
      check("reset toggles", 32'(m.res_toggles), 32'(0));
      check("reset ones", 32'(m.res_ones), 32'(0));
      check("reset ovf", 32'(m.res_ovf), 32'(0));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 3-cycle window: 0000 | 1111 0000 1111
      m_q.push_back(mk_exp(12, 8, 1'b0, 4));
      run_window(16'd3, 4'b0000, 64'h0000_0000_0000_0F0F, -1);
      finish_handshake(1'b0);

      // Zero-length window reports immediately with zero results.
      m_q.push_back(mk_exp(0, 0, 1'b0, 0));
      run_window(16'd0, 4'b1010, 64'h0, -1);
      check("zero len busy", 32'(m.busy), 32'(1));
      finish_handshake(1'b0);

      // Backpressure: 0001 | 0011 0010
      m.res_ready = 1'b0;
      m_q.push_back(mk_exp(2, 3, 1'b0, 1));
      run_window(16'd2, 4'b0001, 64'h23, -1);
      for (int i = 0; i < 5; i++) begin
         check("hold valid", 32'(m.res_valid), 32'(1));
         check("hold busy", 32'(m.busy), 32'(1));
         check("hold toggles", 32'(m.res_toggles), 32'(2));
         check("hold ones", 32'(m.res_ones), 32'(3));
`ifdef TOGGLE_MON_PEAK_EN
         check("hold peak", 32'(m.res_peak), 32'(1));
`endif
         @(posedge clk); #1;
      end
      m.res_ready = 1'b1;
      finish_handshake(1'b0);

      // Start pulses in RUN and in the handshake cycle are ignored.
      m_q.push_back(mk_exp(2, 6, 1'b0, 1));
      run_window(16'd4, 4'b0000, 64'h3311, 1);
      finish_handshake(1'b1);
      repeat (6) @(posedge clk);
      #1;
      check("idle after ignored start", 32'(m.busy), 32'(0));

      // Saturation on the CNT_W=4 instance: 0000 | 1111 0000 x4
      s_q.push_back(mk_exp(15, 15, 1'b1, 4));
      s.start = 1'b1; s.win_len = 16'd8; s.sig_in = 4'b0000;
      @(posedge clk); #1;
      s.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s.sig_in = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         @(posedge clk); #1;
      end
      check("sat valid", 32'(s.res_valid), 32'(1));
      @(posedge clk); #1;
      s_q.push_back(mk_exp(0, 0, 1'b0, 0));
      s.start = 1'b1; s.win_len = 16'd8; s.sig_in = 4'b0000;
      @(posedge clk); #1;
      s.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("sat clean valid", 32'(s.res_valid), 32'(1));
      @(posedge clk); #1;

      // Async reset two cycles into a 10-cycle window.
      do_start(16'd10, 4'b0000);
      m.sig_in = 4'b1111;
      @(posedge clk); #1;
      m.sig_in = 4'b0000;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async rst busy", 32'(m.busy), 32'(0));
      check("async rst valid", 32'(m.res_valid), 32'(0));
      check("async rst toggles", 32'(m.res_toggles), 32'(0));
      check("async rst ones", 32'(m.res_ones), 32'(0));
      check("async rst ovf", 32'(m.res_ovf), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("no valid after reset", 32'(m.res_valid), 32'(0));
      end

      // Clean window after reset: 0000 | 0110
      m_q.push_back(mk_exp(2, 2, 1'b0, 2));
      run_window(16'd1, 4'b0000, 64'h6, -1);
      finish_handshake(1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("main queue drained", 32'(m_q.size()), 32'(0));
      check("sat queue drained", 32'(s_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
